// File: rtl/count_run_ctrl_pkg.sv
// Shared definitions for the count-run control block and its consumers
// (BCD counter, 7-segment display) that decode the run status.
//   run_state_t : FSM state encoding, also exported on the state port.
//   next_state  : run/pause transition on a debounced run press. Clear is
//                 handled by the caller because it overrides everything.
package count_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10
  } run_state_t;

  function automatic run_state_t next_state(input run_state_t cur,
                                            input logic       run_press);
    run_state_t nxt;
    nxt = cur;
    case (cur)
      IDLE:    if (run_press) nxt = RUN;
      RUN:     if (run_press) nxt = PAUSE;
      PAUSE:   if (run_press) nxt = RUN;
      default: nxt = IDLE;  // 2'b11 is unreachable; recover to IDLE
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/count_run_ctrl_if.sv
// Bundle between the run controller and its surroundings.
//   btn_run, btn_clr : raw push-buttons into the controller
//   tick             : one-cycle count enable
//   clr              : one-cycle synchronous clear for the counter
//   running, state   : status for display/decoding
// master = the controller side, slave = the buttons/counter side.
interface count_run_ctrl_if;
  import count_ctrl_pkg::*;

  logic       btn_run;
  logic       btn_clr;
  logic       tick;
  logic       clr;
  logic       running;
  run_state_t state;

  modport master (
    input  btn_run, btn_clr,
    output tick, clr, running, state
  );

  modport slave (
    output btn_run, btn_clr,
    input  tick, clr, running, state
  );

endinterface

// File: rtl/count_run_ctrl_btn_debounce.sv
// Single push-button conditioner.
//   clk, rst : system clock, asynchronous active-low reset
//   btn_raw  : asynchronous, bouncy, active-high button
//   level    : debounced button level
//   press    : one-cycle pulse on a debounced rising edge of level
// The raw input goes through a 2-FF synchroniser; the synchronised value
// must differ from level for DEBOUNCE_CYC consecutive cycles before level
// follows it. Any return to level restarts the count.
module btn_debounce #(
  parameter int DEBOUNCE_CYC = 1_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int DB_W = $clog2(DEBOUNCE_CYC + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYC - 1);

  logic            sync_p0;
  logic            sync_p1;
  logic [DB_W-1:0] cnt;
  logic            level_q;

  // synchroniser stages
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= btn_raw;
      sync_p1 <= sync_p0;
    end
  end

  // debounce counter and accepted level
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt     <= '0;
      level   <= 1'b0;
      level_q <= 1'b0;
    end else begin
      level_q <= level;
      if (sync_p1 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= sync_p1;
        cnt   <= '0;
      end else begin
        cnt <= cnt + DB_W'(1);
      end
    end
  end

  // only the press edge matters; releases are ignored
  assign press = level & ~level_q;

endmodule

// File: rtl/count_run_ctrl.sv
// Run/pause/clear controller feeding the BCD counter.
//   clk  : system clock
//   rst  : asynchronous active-low reset
//   bus  : count_run_ctrl_if.master
//          btn_run/btn_clr in (raw buttons), tick/clr/running/state out
// While in RUN a one-cycle tick is produced every TICK_DIV cycles. PAUSE
// freezes the divider so the tick phase survives a pause/resume. A clear
// press forces IDLE, zeroes the divider, suppresses a coincident tick and
// emits a one-cycle clr. All outputs are registered.
module count_run_ctrl
  import count_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int TICK_DIV     = 33_554_432
) (
  input  logic              clk,
  input  logic              rst,
  count_run_ctrl_if.master  bus
);

  localparam int DIV_W = $clog2(TICK_DIV);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

  logic             run_press;
  logic             clr_press;
  logic             run_level;
  logic             clr_level;
  logic             levels_unused;

  run_state_t       state_q;
  run_state_t       nxt;
  logic [DIV_W-1:0] div;
  logic             tick_q;
  logic             clr_q;
  logic             running_q;

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_run (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_run),
    .level   (run_level),
    .press   (run_press)
  );

  btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_db_clr (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (bus.btn_clr),
    .level   (clr_level),
    .press   (clr_press)
  );

  // the controller acts on press edges only; levels stay local
  assign levels_unused = run_level ^ clr_level;

  // clear overrides any run/pause transition in the same cycle
  always_comb begin
    nxt = next_state(state_q, run_press);
    if (clr_press) nxt = IDLE;
  end

  // FSM and status registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      clr_q     <= 1'b0;
    end else begin
      state_q   <= nxt;
      running_q <= (nxt == RUN);
      clr_q     <= clr_press;
    end
  end

  // divider acts on the current state, so a pause press on the terminal
  // cycle still lets that tick out before the divider freezes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div    <= '0;
      tick_q <= 1'b0;
    end else if (clr_press) begin
      div    <= '0;
      tick_q <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          if (div == DIV_LAST) begin
            div    <= '0;
            tick_q <= 1'b1;
          end else begin
            div    <= div + DIV_W'(1);
            tick_q <= 1'b0;
          end
        end
        PAUSE: begin
          tick_q <= 1'b0;
        end
        default: begin
          div    <= '0;
          tick_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.tick    = tick_q;
  assign bus.clr     = clr_q;
  assign bus.running = running_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_count_run_ctrl.sv
// Directed bench for count_run_ctrl with DEBOUNCE_CYC=4, TICK_DIV=5.
// Inputs are driven and outputs sampled on the falling clock edge. A raw
// button change made at falling edge N becomes a press that the FSM acts on
// at the 7th rising edge after it (2 sync + 4 debounce + 1 edge), so its
// effect is visible at falling edge N+7. Cycle offsets below are relative
// to R, the first falling edge at which state reads RUN.
module tb_count_run_ctrl;

  logic clk;
  logic rst;
  int   n_chk;
  int   n_pass;

  count_run_ctrl_if bus ();

  count_run_ctrl #(
    .DEBOUNCE_CYC (4),
    .TICK_DIV     (5)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h, want %0h at %0t", tag, obs, exp, $time);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, ".state"},   32'(bus.state), 32'd0);
    chk({tag, ".running"}, 32'(bus.running), 32'd0);
    chk({tag, ".tick"},    32'(bus.tick), 32'd0);
    chk({tag, ".clr"},     32'(bus.clr), 32'd0);
  endtask

  initial begin
    n_chk       = 0;
    n_pass      = 0;
    rst         = 1'b0;
    bus.btn_run = 1'b0;
    bus.btn_clr = 1'b0;

    // power-on reset
    cyc(2);
    chk_idle("por");
    chk("por.div", 32'(dut.div), 32'd0);
    rst = 1'b1;
    cyc(2);

    // bouncy run press: 1,0,1 then hold; stable high starts at N0+2
    bus.btn_run = 1'b1;
    cyc(1);
    bus.btn_run = 1'b0;
    cyc(1);
    bus.btn_run = 1'b1;
    cyc(6);
    chk("bounce.pre_state", 32'(bus.state), 32'd0);
    cyc(1);  // R
    chk("bounce.state",   32'(bus.state), 32'd1);
    chk("bounce.running", 32'(bus.running), 32'd1);
    chk("bounce.div",     32'(dut.div), 32'd0);

    // tick every 5 cycles; releasing the button must not produce a press
    for (int i = 1; i <= 20; i++) begin
      cyc(1);
      chk($sformatf("rate.tick%0d", i), 32'(bus.tick), 32'((i % 5) == 0));
      if (i == 1) bus.btn_run = 1'b0;
    end
    chk("rate.state", 32'(bus.state), 32'd1);

    // pause press raised at R+20, acted on at R+27 when div steps 1->2
    bus.btn_run = 1'b1;
    for (int i = 21; i <= 26; i++) begin
      cyc(1);
      chk($sformatf("prepause.tick%0d", i), 32'(bus.tick), 32'(i == 25));
    end
    cyc(1);  // R+27
    chk("pause.state",   32'(bus.state), 32'd2);
    chk("pause.running", 32'(bus.running), 32'd0);
    chk("pause.div",     32'(dut.div), 32'd2);
    bus.btn_run = 1'b0;
    for (int i = 28; i <= 37; i++) begin
      cyc(1);
      chk($sformatf("pause.tick%0d", i), 32'(bus.tick), 32'd0);
    end
    chk("pause.div_held", 32'(dut.div), 32'd2);
    chk("pause.state_held", 32'(bus.state), 32'd2);

    // resume: phase kept, tick 3 cycles after re-entering RUN
    bus.btn_run = 1'b1;
    cyc(7);  // R+44
    chk("resume.state", 32'(bus.state), 32'd1);
    chk("resume.div",   32'(dut.div), 32'd2);
    cyc(1);
    chk("resume.tick45", 32'(bus.tick), 32'd0);
    cyc(1);
    chk("resume.tick46", 32'(bus.tick), 32'd0);
    cyc(1);  // R+47
    chk("resume.tick47", 32'(bus.tick), 32'd1);
    bus.btn_run = 1'b0;

    // run and clear pressed together, landing on the terminal-count cycle
    cyc(8);  // R+55
    bus.btn_run = 1'b1;
    bus.btn_clr = 1'b1;
    cyc(6);  // R+61
    chk("prio.pre_div",   32'(dut.div), 32'd4);
    chk("prio.pre_state", 32'(bus.state), 32'd1);
    cyc(1);  // R+62
    chk("prio.state",   32'(bus.state), 32'd0);
    chk("prio.clr",     32'(bus.clr), 32'd1);
    chk("prio.tick",    32'(bus.tick), 32'd0);
    chk("prio.running", 32'(bus.running), 32'd0);
    chk("prio.div",     32'(dut.div), 32'd0);
    bus.btn_run = 1'b0;
    bus.btn_clr = 1'b0;
    cyc(1);
    chk_idle("prio.after");

    // back to RUN, then async reset one cycle before a tick is due
    cyc(7);  // R+70
    bus.btn_run = 1'b1;
    cyc(7);  // R+77
    chk("rerun.state", 32'(bus.state), 32'd1);
    bus.btn_run = 1'b0;
    cyc(4);  // R+81
    chk("rerun.div", 32'(dut.div), 32'd4);
    #2;
    rst         = 1'b0;
    bus.btn_clr = 1'b1;
    #1;
    chk_idle("async_rst");
    chk("async_rst.div", 32'(dut.div), 32'd0);
    cyc(2);
    chk_idle("rst_hold");
    rst = 1'b1;  // Q, clear button still held

    // held through reset release: exactly one clr after debounce
    cyc(6);
    chk("held.clr_q6", 32'(bus.clr), 32'd0);
    cyc(1);
    chk("held.clr_q7", 32'(bus.clr), 32'd1);
    chk("held.state",  32'(bus.state), 32'd0);
    for (int i = 8; i <= 15; i++) begin
      cyc(1);
      chk($sformatf("held.clr_q%0d", i), 32'(bus.clr), 32'd0);
    end
    bus.btn_clr = 1'b0;
    cyc(8);  // Q+23
    bus.btn_clr = 1'b1;
    cyc(6);
    chk("repress.clr_q29", 32'(bus.clr), 32'd0);
    cyc(1);
    chk("repress.clr_q30", 32'(bus.clr), 32'd1);
    cyc(1);
    chk("repress.clr_q31", 32'(bus.clr), 32'd0);
    bus.btn_clr = 1'b0;

    // 3-cycle raw pulse is shorter than the debounce window
    cyc(8);
    bus.btn_run = 1'b1;
    cyc(3);
    bus.btn_run = 1'b0;
    for (int i = 0; i < 12; i++) begin
      cyc(1);
      chk($sformatf("short.state%0d", i), 32'(bus.state), 32'd0);
    end
    chk("short.running", 32'(bus.running), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
